// File: rtl/gpio_pad_seq.sv
// ---------------------------------------------------------------------------
// gpio_pad_seq
//
// Sequences GPIO direction changes onto pad cells one pad at a time. When the
// peripheral requests a new direction for a pad, that pad is first parked in
// a safe state (driver off, receiver off) for GUARD_CYCLES cycles. Only then
// is the new direction applied. Pending pads are served round-robin.
//
// Parameters
//   NUM_PADS      number of pads sequenced (1..32)
//   GUARD_CYCLES  safe-state dwell per direction change (>= 1)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   gpio_dir_i   requested direction per pad (1 = output)
//   gpio_out_i   output data from the GPIO peripheral
//   gpio_pe_i    requested pull-enable per pad
//   pad_c_i      pad receiver outputs
//   pad_i_o      pad driver data
//   pad_ds_o     pad drive strength
//   pad_oen_o    pad output enable, active low
//   pad_ie_o     pad input enable
//   pad_pe_o     pad pull enable (gpio_pe_i delayed one cycle)
//   gpio_in_o    input data returned to the peripheral
//   busy_o       a direction change is in progress
//   done_o       one-cycle pulse when a direction change completes
//   cur_pad_o    index of the pad being sequenced (0 when idle)
// ---------------------------------------------------------------------------
module gpio_pad_seq #(
    parameter int NUM_PADS     = 11,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PADS-1:0] gpio_dir_i,
    input  logic [NUM_PADS-1:0] gpio_out_i,
    input  logic [NUM_PADS-1:0] gpio_pe_i,
    input  logic [NUM_PADS-1:0] pad_c_i,
    output logic [NUM_PADS-1:0] pad_i_o,
    output logic [NUM_PADS-1:0] pad_ds_o,
    output logic [NUM_PADS-1:0] pad_oen_o,
    output logic [NUM_PADS-1:0] pad_ie_o,
    output logic [NUM_PADS-1:0] pad_pe_o,
    output logic [NUM_PADS-1:0] gpio_in_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [4:0]          cur_pad_o
);

    localparam int               CNT_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [4:0]       LAST_PAD = 5'(NUM_PADS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAFE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_PADS-1:0] dir_q;
    logic [NUM_PADS-1:0] pending;
    logic [4:0]          rr_q;
    logic [4:0]          sel_q;
    logic                tgt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                guard_done;

    // Arbiter results
    logic       found_hi, found_lo;
    logic [4:0] idx_hi, idx_lo;
    logic       tgt_hi, tgt_lo;
    logic       grant_vld;
    logic [4:0] grant_idx;
    logic       grant_tgt;

    assign pending    = gpio_dir_i ^ dir_q;
    assign guard_done = (cnt_q == CNT_LAST);

    // Round-robin arbiter: the lowest pending pad at or above rr_q wins;
    // if there is none, the search wraps around to the lowest pending pad
    // below rr_q.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path through the block leaves it unassigned
        // and no latch is inferred.
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        tgt_hi   = 1'b0;
        tgt_lo   = 1'b0;
        for (int k = 0; k < NUM_PADS; k++) begin
            if (pending[k]) begin
                if (5'(k) >= rr_q) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        idx_hi   = 5'(k);
                        tgt_hi   = gpio_dir_i[k];
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = 5'(k);
                    tgt_lo   = gpio_dir_i[k];
                end
            end
        end
        grant_vld = found_hi | found_lo;
        grant_idx = found_hi ? idx_hi : idx_lo;
        grant_tgt = found_hi ? tgt_hi : tgt_lo;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic and the completion pulse
    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (grant_vld) state_d = ST_SAFE;
            ST_SAFE: if (guard_done) state_d = ST_DONE;
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: grant latch, guard counter, applied direction, pointer.
    // tgt_q is captured at grant time. A request that changes during SAFE
    // is therefore not seen until the next arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: dir_q is reset along with the rest of the state.
            // A pad must never come out of reset driving, and a reset
            // taken mid-SAFE must discard the pending target.
            dir_q    <= '0;
            rr_q     <= '0;
            sel_q    <= '0;
            tgt_q    <= 1'b0;
            cnt_q    <= '0;
            pad_pe_o <= '0;
        end else begin
            pad_pe_o <= gpio_pe_i;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        sel_q <= grant_idx;
                        tgt_q <= grant_tgt;
                        cnt_q <= '0;
                    end
                end
                ST_SAFE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (guard_done) begin
                        for (int k = 0; k < NUM_PADS; k++) begin
                            if (5'(k) == sel_q) dir_q[k] <= tgt_q;
                        end
                    end
                end
                ST_DONE: begin
                    rr_q <= (sel_q == LAST_PAD) ? 5'd0 : sel_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Pad control. The pad in transition is parked with its driver and
    // receiver off. Every other pad follows its applied direction.
    always_comb begin
        pad_i_o   = '0;
        pad_ds_o  = '0;
        pad_oen_o = '1;
        pad_ie_o  = '1;
        for (int k = 0; k < NUM_PADS; k++) begin
            if (state_q == ST_SAFE && 5'(k) == sel_q) begin
                pad_oen_o[k] = 1'b1;
                pad_ie_o[k]  = 1'b0;
                pad_ds_o[k]  = 1'b0;
                pad_i_o[k]   = 1'b0;
            end else if (dir_q[k]) begin
                pad_oen_o[k] = 1'b0;
                pad_ie_o[k]  = 1'b0;
                pad_ds_o[k]  = 1'b1;
                pad_i_o[k]   = gpio_out_i[k];
            end
        end
    end

    assign gpio_in_o = pad_c_i & pad_ie_o;
    assign busy_o    = (state_q != ST_IDLE);
    assign cur_pad_o = busy_o ? sel_q : 5'd0;

endmodule

// File: tb/tb_gpio_pad_seq.sv
// ---------------------------------------------------------------------------
// tb_gpio_pad_seq
//
// Self-checking bench for gpio_pad_seq. A transaction-level model follows the
// DUT. It tracks the applied direction per pad, the round-robin pointer and
// the start cycle of the current direction change. From these it derives
// every output on every cycle. Directed scenarios add literal expectations
// computed by hand. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_gpio_pad_seq;

    localparam int N = 11;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] dir_i = '0;
    logic [N-1:0] out_i = '0;
    logic [N-1:0] pe_i  = '0;
    logic [N-1:0] c_i   = '0;
    logic [N-1:0] pad_i_o, pad_ds_o, pad_oen_o, pad_ie_o, pad_pe_o, gpio_in_o;
    logic         busy_o, done_o;
    logic [4:0]   cur_pad_o;

    always #5 clk = ~clk;

    gpio_pad_seq #(.NUM_PADS(N), .GUARD_CYCLES(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_dir_i (dir_i),
        .gpio_out_i (out_i),
        .gpio_pe_i  (pe_i),
        .pad_c_i    (c_i),
        .pad_i_o    (pad_i_o),
        .pad_ds_o   (pad_ds_o),
        .pad_oen_o  (pad_oen_o),
        .pad_ie_o   (pad_ie_o),
        .pad_pe_o   (pad_pe_o),
        .gpio_in_o  (gpio_in_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cur_pad_o  (cur_pad_o)
    );

    int tests = 0;
    int fails = 0;

    // Transaction model: a direction change that starts (is granted) in
    // cycle m_s is safe in cycles m_s+1 .. m_s+G and completes in m_s+G+1.
    logic [N-1:0] m_dir = '0;
    logic [N-1:0] m_pe  = '0;
    int           m_rr  = 0;
    int           m_sel = 0;
    int           m_s   = 0;
    int           m_cyc = 0;
    bit           m_active = 1'b0;
    logic         m_tgt = 1'b0;

    localparam logic [N-1:0] ALL1 = {N{1'b1}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs the
    // DUT will sample at that edge.
    task automatic model_update();
        if (rst) begin
            m_dir    = '0;
            m_pe     = '0;
            m_rr     = 0;
            m_sel    = 0;
            m_active = 1'b0;
        end else begin
            m_pe = pe_i;
            if (m_active) begin
                if (m_cyc - m_s == G) begin
                    m_dir[m_sel] = m_tgt;
                end else if (m_cyc - m_s == G + 1) begin
                    m_rr     = (m_sel + 1) % N;
                    m_active = 1'b0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_rr + i) % N;
                    if (!m_active && dir_i[k] !== m_dir[k]) begin
                        m_active = 1'b1;
                        m_s      = m_cyc;
                        m_sel    = k;
                        m_tgt    = dir_i[k];
                    end
                end
            end
        end
        m_cyc++;
    endtask

    task automatic check_all();
        logic [N-1:0] e_i, e_ds, e_oen, e_ie;
        int  off;
        bit  safe, done;
        off  = m_cyc - m_s;
        safe = m_active && off >= 1 && off <= G;
        done = m_active && off == G + 1;
        for (int k = 0; k < N; k++) begin
            if (safe && k == m_sel) begin
                e_oen[k] = 1'b1; e_ie[k] = 1'b0; e_ds[k] = 1'b0; e_i[k] = 1'b0;
            end else if (m_dir[k]) begin
                e_oen[k] = 1'b0; e_ie[k] = 1'b0; e_ds[k] = 1'b1; e_i[k] = out_i[k];
            end else begin
                e_oen[k] = 1'b1; e_ie[k] = 1'b1; e_ds[k] = 1'b0; e_i[k] = 1'b0;
            end
        end
        check("pad_i",   32'(pad_i_o),   32'(e_i));
        check("pad_ds",  32'(pad_ds_o),  32'(e_ds));
        check("pad_oen", 32'(pad_oen_o), 32'(e_oen));
        check("pad_ie",  32'(pad_ie_o),  32'(e_ie));
        check("pad_pe",  32'(pad_pe_o),  32'(m_pe));
        check("gpio_in", 32'(gpio_in_o), 32'(c_i & e_ie));
        check("busy",    32'(busy_o),    32'(m_active));
        check("done",    32'(done_o),    32'(done));
        check("cur_pad", 32'(cur_pad_o), m_active ? 32'(m_sel) : 32'd0);
    endtask

    // One clock: update the model, let the edge pass, compare away from it.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset for one edge. The cycle after return is "cycle 0", with d
    // already applied to gpio_dir_i.
    task automatic do_reset(input logic [N-1:0] d);
        rst   = 1'b1;
        dir_i = d;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int dc;
        int last;

        out_i = ALL1;
        c_i   = N'(11'h5A5);
        pe_i  = N'(11'h0F3);

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_oen",  32'(pad_oen_o), 32'(ALL1));
        check("rst_ie",   32'(pad_ie_o),  32'(ALL1));
        check("rst_ds",   32'(pad_ds_o),  0);
        check("rst_i",    32'(pad_i_o),   0);
        check("rst_busy", 32'(busy_o),    0);
        check("rst_done", 32'(done_o),    0);
        check("rst_cur",  32'(cur_pad_o), 0);

        // Idle for 20 cycles with all pads as inputs
        rst = 1'b0;
        dc  = 0;
        repeat (20) begin
            step();
            if (done_o) dc++;
        end
        check("idle_done_count", 32'(dc), 0);
        check("idle_busy", 32'(busy_o), 0);
        check("idle_oen", 32'(pad_oen_o), 32'(ALL1));
        check("idle_gpio_in", 32'(gpio_in_o), 32'(11'h5A5));

        // Single pad 3 input -> output
        do_reset(N'(11'h008));
        for (int c = 1; c <= G; c++) begin
            step();
            check($sformatf("p3_safe_oen_c%0d", c), 32'(pad_oen_o[3]), 1);
            check($sformatf("p3_safe_ie_c%0d", c),  32'(pad_ie_o[3]),  0);
            check($sformatf("p3_safe_ds_c%0d", c),  32'(pad_ds_o[3]),  0);
        end
        step();
        check("p3_c5_oen",  32'(pad_oen_o[3]), 0);
        check("p3_c5_ds",   32'(pad_ds_o[3]),  1);
        check("p3_c5_i",    32'(pad_i_o[3]),   1);
        check("p3_c5_done", 32'(done_o),       1);
        step();
        check("p3_c6_busy", 32'(busy_o), 0);
        check("p3_c6_done", 32'(done_o), 0);

        // Four pads at once: grants 0,1,2,3; last done in cycle 23
        do_reset(N'(11'h00F));
        dc   = 0;
        last = -1;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (done_o) begin
                dc++;
                last = c;
            end
            if (c == 1 || c == 7 || c == 13 || c == 19)
                check($sformatf("quad_grant_c%0d", c), 32'(cur_pad_o), 32'((c - 1) / 6));
        end
        check("quad_done_count", 32'(dc), 4);
        check("quad_last_done", 32'(last), 23);

        // Wrap-around: pointer at 5 after pad 4; pads 2 and 9 -> 9 first
        do_reset(N'(11'h010));
        repeat (5) step();
        check("rr_p4_done", 32'(done_o), 1);
        dir_i = N'(11'h214);
        step();
        check("rr_idle_gap", 32'(busy_o), 0);
        step();
        check("rr_first_9", 32'(cur_pad_o), 9);
        repeat (6) step();
        check("rr_then_2", 32'(cur_pad_o), 2);

        // Request reverts during SAFE: applied, then re-sequenced back
        do_reset(N'(11'h002));
        step();
        dir_i = '0;
        repeat (4) step();
        check("rev_done1", 32'(done_o), 1);
        check("rev_oen_out", 32'(pad_oen_o[1]), 0);
        step();
        check("rev_gap", 32'(busy_o), 0);
        step();
        check("rev_regrant", 32'(cur_pad_o), 1);
        repeat (4) step();
        check("rev_done2", 32'(done_o), 1);
        check("rev_oen_in", 32'(pad_oen_o[1]), 1);
        check("rev_ie_in",  32'(pad_ie_o[1]),  1);

        // Reset in the second SAFE cycle of pad 7
        do_reset(N'(11'h080));
        step();
        step();
        check("mid_rst_sel", 32'(cur_pad_o), 7);
        rst = 1'b1;
        step();
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_done", 32'(done_o), 0);
        check("mid_rst_oen",  32'(pad_oen_o), 32'(ALL1));
        check("mid_rst_ie",   32'(pad_ie_o),  32'(ALL1));
        rst = 1'b0;
        step();
        check("mid_rst_rereq", 32'(cur_pad_o), 7);

        // Randomized traffic, including changes during SAFE and rare resets
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) dir_i[$urandom_range(0, N - 1)] ^= 1'b1;
            out_i = N'($urandom);
            pe_i  = N'($urandom);
            c_i   = N'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_pad_seq.md
GPIO_PAD_SEQ -- requirements
Module: gpio_pad_seq

Interface
- REQ-001 Parameter NUM_PADS, default 11: number of GPIO pads sequenced (1..32).
- REQ-002 Parameter GUARD_CYCLES, default 4: safe-state dwell per direction change (>=1).
- REQ-003 clk  in  1  single clock; all state updates on rising edge.
- REQ-004 rst  in  1  reset, synchronous, active-high.
- REQ-005 gpio_dir_i  in  NUM_PADS  requested direction from GPIO peripheral (1=output).
- REQ-006 gpio_out_i  in  NUM_PADS  output data from GPIO peripheral.
- REQ-007 gpio_pe_i  in  NUM_PADS  requested pull-enable (padcfg bit 0).
- REQ-008 pad_c_i  in  NUM_PADS  pad receiver outputs (C).
- REQ-009 pad_i_o, pad_ds_o, pad_oen_o, pad_ie_o, pad_pe_o  out  NUM_PADS each  pad cell controls I, DS, OEN, IE, PE.
- REQ-010 gpio_in_o  out  NUM_PADS  input data returned to GPIO peripheral.
- REQ-011 busy_o  out  1  high while state is not IDLE.
- REQ-012 done_o  out  1  one-cycle pulse when a direction change completes.
- REQ-013 cur_pad_o  out  5  index of pad being sequenced (0 when IDLE).

Function
- REQ-014 Block SHALL hold applied-direction register dir_q[NUM_PADS]; pad k pending when gpio_dir_i[k] != dir_q[k].
- REQ-015 FSM states SHALL be IDLE, SAFE, DONE; only one pad in transition at any time.
- REQ-016 IDLE: if any pad pending, round-robin grant starting at pointer rr_q, searching upward with wrap; latch sel_q=winner, tgt_q=gpio_dir_i[winner]; next state SAFE, counter=0.
- REQ-017 SAFE: counter increments each cycle; after GUARD_CYCLES cycles in SAFE, dir_q[sel_q]<=tgt_q, next DONE.
- REQ-018 DONE: done_o=1 for one cycle; rr_q<=sel_q+1 (wrap NUM_PADS-1 -> 0); next IDLE.
- REQ-019 Latency: pending visible in IDLE at cycle 0 -> pad safe in cycles 1..GUARD_CYCLES -> new config from cycle GUARD_CYCLES+1 (DONE) onward.
- REQ-020 Pad in SAFE (k==sel_q, state SAFE): OEN=1, IE=0, DS=0, I=0.
- REQ-021 Otherwise, dir_q[k]=1: OEN=0, IE=0, DS=1, I=gpio_out_i[k]; dir_q[k]=0: OEN=1, IE=1, DS=0, I=0.
- REQ-022 pad_pe_o SHALL be gpio_pe_i registered one cycle, independent of FSM.
- REQ-023 gpio_in_o[k] SHALL equal pad_c_i[k] & pad_ie_o[k] (combinational).
- REQ-024 gpio_dir_i changes on sel_q during SAFE SHALL NOT abort; tgt_q is applied, and any remaining mismatch is re-requested via normal arbitration.
- REQ-025 Non-selected pads SHALL keep their applied config unchanged while another pad sequences, even if they are pending.
- REQ-026 Back-to-back: minimum one IDLE cycle between DONE and next SAFE.
- REQ-027 Counter width SHALL be clog2(GUARD_CYCLES+1); no overflow possible.

Reset
- REQ-028 On rst=1 at a clock edge: state=IDLE, dir_q=0, rr_q=0, sel_q=0, counter=0, pad_pe_o=0; rst has priority over all other activity, including mid-SAFE.
- REQ-029 Outputs after reset: all pads OEN=1, IE=1, DS=0, I=0, PE=0; busy_o=0, done_o=0, cur_pad_o=0.
- REQ-030 Reset during SAFE SHALL discard tgt_q; dir_q returns to 0, the pad goes to input config, and any nonzero gpio_dir_i is re-requested after reset deasserts.

Verification
- REQ-031 Reset, gpio_dir_i=0 -> all pads input config, busy_o=0 for 20 cycles, no done_o.
- REQ-032 gpio_dir_i[3] 0->1 at cycle 0, GUARD=4 -> pad 3 safe cycles 1-4; cycle 5 OEN=0, DS=1, done_o=1; cycle 6 busy_o=0.
- REQ-033 gpio_dir_i=0x00F set simultaneously from reset -> grants in order 0,1,2,3; each safe 4 cycles; 4 done_o pulses; last done at cycle 23.
- REQ-034 Pads 2 and 9 pending continuously, rr_q=5 -> pad 9 granted first, then pad 2 (wrap).
- REQ-035 Pad 1 in SAFE, gpio_dir_i[1] reverts to 0 -> pad 1 applied as output at DONE, then re-sequenced back to input.
- REQ-036 rst asserted at 2nd SAFE cycle of pad 7 -> next cycle all pads input, busy_o=0, no done_o.
